// File: rtl/alu32.sv
// Registered integer ALU for the execute stage: eight operations selected by fun,
// result and status flags appear one clock after an in_valid cycle.
module alu32 #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fun,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_NOT = 3'd5;
  localparam logic [2:0] F_SLT = 3'd6;
  localparam logic [2:0] F_SLL = 3'd7;

  logic [WIDTH-1:0] y_reg, y_next;
  logic             carry_reg, carry_next;
  logic             overflow_reg, overflow_next;
  logic             valid_reg;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] and_v, or_v, xor_v, not_v;
  logic             slt;

  // Extra top bit holds the ADD carry-out; for SUB it is set exactly when a < b unsigned.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign slt  = $signed(a) < $signed(b);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_v[gi] = a[gi] & b[gi];
      assign or_v[gi]  = a[gi] | b[gi];
      assign xor_v[gi] = a[gi] ^ b[gi];
      assign not_v[gi] = ~a[gi];
    end
  endgenerate

  always_comb begin
    y_next        = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    case (fun)
      F_ADD: begin
        y_next        = sum[WIDTH-1:0];
        carry_next    = sum[WIDTH];
        overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        y_next        = diff[WIDTH-1:0];
        carry_next    = diff[WIDTH];
        overflow_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      F_AND:   y_next = and_v;
      F_OR:    y_next = or_v;
      F_XOR:   y_next = xor_v;
      F_NOT:   y_next = not_v;
      F_SLT:   y_next = {{(WIDTH-1){1'b0}}, slt};
      F_SLL:   y_next = a << b[SHW-1:0];
      default: y_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg        <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        y_reg        <= y_next;
        carry_reg    <= carry_next;
        overflow_reg <= overflow_next;
      end
    end
  end

  assign y         = y_reg;
  assign out_valid = valid_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  // Status flags follow the registered result so they always agree with y.
  assign zero      = (y_reg == '0);
  assign negative  = y_reg[WIDTH-1];

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: expected results queued at drive time and
// compared one cycle later when out_valid presents the result.
module tb_alu32;

  typedef struct packed {
    logic [31:0] y;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    res_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  fun = '0;
  logic [31:0] y;
  logic        out_valid, zero, negative, carry, overflow;

  res_t sb[$];
  res_t exp_r, obs;
  int   errors = 0;
  int   checks = 0;

  alu32 #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .fun(fun),
    .y(y), .out_valid(out_valid), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign obs = '{y: y, c: carry, v: overflow, z: zero, n: negative};

  function automatic vec_t mk(logic [2:0] f, logic [31:0] va, logic [31:0] vb,
                              logic [31:0] ey, logic ec, logic ev, logic ez, logic en);
    vec_t t;
    t.f = f; t.a = va; t.b = vb;
    t.e = '{y: ey, c: ec, v: ev, z: ez, n: en};
    return t;
  endfunction

  // Reference model used for the randomised stream.
  function automatic res_t model(logic [2:0] f, logic [31:0] va, logic [31:0] vb);
    res_t r;
    logic [32:0] wide;
    r = '0;
    case (f)
      3'd0: begin
        wide = 33'(va) + 33'(vb);
        r.y = wide[31:0];
        r.c = wide[32];
        r.v = (va[31] == vb[31]) && (r.y[31] != va[31]);
      end
      3'd1: begin
        r.y = va - vb;
        r.c = (va < vb);
        r.v = (va[31] != vb[31]) && (r.y[31] != va[31]);
      end
      3'd2: r.y = va & vb;
      3'd3: r.y = va | vb;
      3'd4: r.y = va ^ vb;
      3'd5: r.y = ~va;
      3'd6: r.y = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      default: r.y = va << vb[4:0];
    endcase
    r.z = (r.y == 32'd0);
    r.n = r.y[31];
    return r;
  endfunction

  task automatic apply(vec_t t);
    in_valid = 1'b1;
    fun = t.f;
    a = t.a;
    b = t.b;
    sb.push_back(t.e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got v=%b y=%h c%b v%b z%b n%b, want v=0 y=0 z=1", out_valid, y, carry, overflow, zero, negative);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got v=%b y=%h z%b, want v=0 y=0 z=1", out_valid, y, zero);
    end
  endtask

  task automatic run_table(string name, vec_t v[]);
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      @(posedge clk);
      #1;
      exp_r = sb.pop_front();
      checks++;
      if ({out_valid, obs} !== {1'b1, exp_r}) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%b y=%h c%b v%b z%b n%b, want v=1 y=%h c%b v%b z%b n%b",
                 name, i, out_valid, y, carry, overflow, zero, negative,
                 exp_r.y, exp_r.c, exp_r.v, exp_r.z, exp_r.n);
      end else begin
        $display("ok %s[%0d] fun=%0d y=%h", name, i, fun, y);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[] = new[3];
    v[0] = mk(3'd0, 32'h10,  32'h110,  32'h0000_0120, 0, 0, 0, 0);
    v[1] = mk(3'd1, 32'h110, 32'h1000, 32'hFFFF_F110, 1, 0, 0, 1);
    v[2] = mk(3'd1, 32'h5,   32'h5,    32'h0,         0, 0, 1, 0);
    run_table("arith", v);
  endtask

  task automatic test_logic();
    vec_t v[] = new[4];
    v[0] = mk(3'd2, 32'h1010, 32'h111,  32'h0000_0010, 0, 0, 0, 0);
    v[1] = mk(3'd3, 32'h1011, 32'h1001, 32'h0000_1011, 0, 0, 0, 0);
    v[2] = mk(3'd4, 32'h1001, 32'h110,  32'h0000_1111, 0, 0, 0, 0);
    v[3] = mk(3'd5, 32'h10,   32'hFFFF, 32'hFFFF_FFEF, 0, 0, 0, 1);
    run_table("logic", v);
  endtask

  task automatic test_cmp_shift();
    vec_t v[] = new[5];
    v[0] = mk(3'd6, 32'h1000,      32'h1000, 32'h0,          0, 0, 1, 0);
    v[1] = mk(3'd6, 32'hFFFF_FFFF, 32'h1,    32'h1,          0, 0, 0, 0);
    v[2] = mk(3'd6, 32'h1,         32'hFFFF_FFFF, 32'h0,     0, 0, 1, 0);
    v[3] = mk(3'd7, 32'h2,         32'h2,    32'h8,          0, 0, 0, 0);
    v[4] = mk(3'd7, 32'h1,         32'h3F,   32'h8000_0000,  0, 0, 0, 1);
    run_table("cmpshift", v);
  endtask

  task automatic test_boundaries();
    vec_t v[] = new[4];
    v[0] = mk(3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 1, 0);
    v[1] = mk(3'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1);
    v[2] = mk(3'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 0, 0);
    v[3] = mk(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0,         1, 1, 1, 0);
    run_table("bound", v);
  endtask

  task automatic test_back_to_back();
    vec_t v[] = new[40];
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] ra, rb;
      f  = 3'(i % 8);
      ra = $urandom();
      rb = (i % 5 == 0) ? ra : $urandom();
      v[i].f = f;
      v[i].a = ra;
      v[i].b = rb;
      v[i].e = model(f, ra, rb);
    end
    run_table("stream", v);
  endtask

  task automatic test_valid_drop();
    vec_t v[] = new[1];
    v[0] = mk(3'd0, 32'h1234, 32'h1, 32'h0000_1235, 0, 0, 0, 0);
    run_table("drop_pre", v);
    in_valid = 1'b0;
    fun = 3'd5;
    a = 32'h0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, v[0].e}) begin
      errors++;
      $display("FAIL valid_drop: got v=%b y=%h z%b n%b, want v=0 y=%h (held)", out_valid, y, zero, negative, v[0].e.y);
    end else begin
      $display("ok valid_drop y=%h held", y);
    end
  endtask

  task automatic test_async_reset();
    vec_t v[] = new[1];
    v[0] = mk(3'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    run_table("areset_pre", v);
    apply(mk(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 1, 0));
    sb.delete();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got v=%b y=%h c%b z%b, want v=0 y=0 c0 z=1 before edge", out_valid, y, carry, zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_discard: got v=%b y=%h c%b, want v=0 y=0 c0", out_valid, y, carry);
    end else begin
      $display("ok async_reset cleared");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_cmp_shift();
    test_boundaries();
    test_back_to_back();
    test_valid_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
